mbgd_sample_mem: RTL and testbench

Sample memory stage directly downstream of `mbgd_regfile`. It holds the 2^ADDR x DATA sample RAM that the regfile writes and reads through its RAM_* port. It also contains a mini-batch sequencer that streams a contiguous window of samples to the MBGD compute core over a valid/ready interface. The regfile port has strict priority over the sequencer for the single memory port.

---
 rtl/mbgd_sample_mem.sv | 132 +++++++++++++
 tb/tb_mbgd_sample_mem.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mbgd_sample_mem.sv
// mbgd_sample_mem: sample RAM behind the regfile RAM_* port, plus a mini-batch
// sequencer that streams a contiguous (wrapping) window of samples over
// valid/ready. The regfile always wins the single memory port; the sequencer
// simply retries its read on the next free cycle.
module mbgd_sample_mem #(
  parameter int ADDR = 8,
  parameter int DATA = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            RAM_CS,
  input  logic            RAM_RD,
  input  logic [ADDR-1:0] RAM_Addr,
  input  logic [DATA-1:0] RAM_dataIn,
  output logic [DATA-1:0] RAM_dataOut,
  output logic            RAM_rvalid,
  input  logic            bat_start,
  input  logic [ADDR-1:0] bat_base,
  input  logic [ADDR:0]   bat_len,
  output logic [DATA-1:0] bat_data,
  output logic            bat_valid,
  input  logic            bat_ready,
  output logic            bat_last,
  output logic            bat_busy,
  output logic            bat_done
);

  typedef enum logic [1:0] {IDLE, FETCH, OUT, DONE} state_t;

  state_t          state;
  logic [ADDR-1:0] base;
  logic [ADDR:0]   len;
  logic [ADDR:0]   idx;
  logic [DATA-1:0] mem [0:(2**ADDR)-1];

  logic [ADDR:0]   idx_nxt;
  logic [ADDR-1:0] rd_addr;
  logic            is_last;
  logic            next_last;

  // In OUT the read being issued is for the beat after the one on bat_data,
  // so the address uses the incremented index; in FETCH it uses idx itself.
  // Only the low ADDR bits of the index matter: addresses wrap mod 2^ADDR.
  assign idx_nxt   = idx + 1'b1;
  assign rd_addr   = base + ((state == OUT) ? idx_nxt[ADDR-1:0] : idx[ADDR-1:0]);
  assign is_last   = (idx == len - 1'b1);
  assign next_last = (idx_nxt == len - 1'b1);

  // Memory write: regfile only, array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (RAM_CS && !RAM_RD) mem[RAM_Addr] <= RAM_dataIn;
  end

  // Regfile read: one-cycle latency, data holds between reads.
  always_ff @(posedge clk) begin
    if (resetn) begin
      RAM_dataOut <= '0;
      RAM_rvalid  <= 1'b0;
    end else begin
      RAM_rvalid <= RAM_CS && RAM_RD;
      if (RAM_CS && RAM_RD) RAM_dataOut <= mem[RAM_Addr];
    end
  end

  // Sequencer FSM with registered stream/status outputs.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state     <= IDLE;
      base      <= '0;
      len       <= '0;
      idx       <= '0;
      bat_data  <= '0;
      bat_valid <= 1'b0;
      bat_last  <= 1'b0;
      bat_busy  <= 1'b0;
      bat_done  <= 1'b0;
    end else begin
      bat_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bat_start) begin
            base     <= bat_base;
            len      <= bat_len;
            idx      <= '0;
            bat_busy <= 1'b1;
            if (bat_len == '0) begin
              state    <= DONE;
              bat_done <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (!RAM_CS) begin
            bat_data  <= mem[rd_addr];
            bat_valid <= 1'b1;
            bat_last  <= is_last;
            state     <= OUT;
          end
        end
        OUT: begin
          if (bat_ready) begin
            if (is_last) begin
              state     <= DONE;
              bat_valid <= 1'b0;
              bat_last  <= 1'b0;
              bat_done  <= 1'b1;
            end else begin
              idx <= idx_nxt;
              if (!RAM_CS) begin
                // back-to-back beat: next read lands while this one retires
                bat_data <= mem[rd_addr];
                bat_last <= next_last;
              end else begin
                state     <= FETCH;
                bat_valid <= 1'b0;
                bat_last  <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bat_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbgd_sample_mem.sv
// Scoreboard bench for mbgd_sample_mem: stimulus pushes expected regfile read
// data and expected stream beats into queues; a negedge monitor pops and
// compares whenever the DUT presents RAM_rvalid or an accepted beat.
module tb_mbgd_sample_mem;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       RAM_CS = 1'b0, RAM_RD = 1'b0;
  logic [7:0] RAM_Addr = '0, RAM_dataIn = '0;
  logic [7:0] RAM_dataOut;
  logic       RAM_rvalid;
  logic       bat_start = 1'b0;
  logic [7:0] bat_base = '0;
  logic [8:0] bat_len = '0;
  logic [7:0] bat_data;
  logic       bat_valid, bat_ready = 1'b0, bat_last, bat_busy, bat_done;

  mbgd_sample_mem #(.ADDR(8), .DATA(8)) dut (
    .clk(clk), .resetn(resetn),
    .RAM_CS(RAM_CS), .RAM_RD(RAM_RD), .RAM_Addr(RAM_Addr), .RAM_dataIn(RAM_dataIn),
    .RAM_dataOut(RAM_dataOut), .RAM_rvalid(RAM_rvalid),
    .bat_start(bat_start), .bat_base(bat_base), .bat_len(bat_len),
    .bat_data(bat_data), .bat_valid(bat_valid), .bat_ready(bat_ready),
    .bat_last(bat_last), .bat_busy(bat_busy), .bat_done(bat_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [7:0] ram_q[$];
  logic [8:0] bat_q[$];   // {last, data}
  logic empty_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  logic       pend_done = 1'b0, stalled = 1'b0, held_last = 1'b0;
  logic [7:0] held = '0;
  logic [8:0] e;
  always @(negedge clk) begin
    if (resetn) begin
      pend_done = 1'b0;
      stalled   = 1'b0;
    end else begin
      if (pend_done) check("done_after_last", bat_done, 1);
      else if (bat_done) check("unexpected_done", empty_ok, 1);
      pend_done = 1'b0;
      if (stalled) begin
        check("stall_valid", bat_valid, 1);
        check("stall_data", bat_data, held);
        check("stall_last", bat_last, held_last);
      end
      if (RAM_rvalid) begin
        if (ram_q.size() == 0) check("rvalid_unexpected", 1, 0);
        else check("ram_rdata", RAM_dataOut, ram_q.pop_front());
      end
      if (bat_valid && bat_ready) begin
        if (bat_q.size() == 0) check("beat_unexpected", 1, 0);
        else begin
          e = bat_q.pop_front();
          check("beat_data", bat_data, e[7:0]);
          check("beat_last", bat_last, e[8]);
        end
        if (bat_last) pend_done = 1'b1;
      end
      stalled   = bat_valid && !bat_ready;
      held      = bat_data;
      held_last = bat_last;
    end
  end

  // All driver tasks start and end 1ns after a rising edge.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    RAM_CS = 1; RAM_RD = 0; RAM_Addr = a; RAM_dataIn = d;
    @(posedge clk); #1;
    RAM_CS = 0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp);
    ram_q.push_back(exp);
    RAM_CS = 1; RAM_RD = 1; RAM_Addr = a;
    @(posedge clk); #1;
    RAM_CS = 0; RAM_RD = 0;
    @(negedge clk);
    check("rd_latency", RAM_rvalid, 1);
    @(posedge clk); #1;
  endtask

  task automatic start(input logic [7:0] b, input logic [8:0] l);
    bat_start = 1; bat_base = b; bat_len = l;
    @(posedge clk); #1;
    bat_start = 0;
  endtask

  // Counts negedges after the start edge until bat_done; ends 1ns after posedge.
  task automatic wait_done(output int n, output int first_v);
    n = 0; first_v = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      n++;
      if (bat_valid && first_v == 0) first_v = n;
      if (bat_done) break;
    end
    if (!bat_done) check("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  int n, fv;
  logic [7:0] a;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dataOut", RAM_dataOut, 0);
    check("rst_rvalid", RAM_rvalid, 0);
    check("rst_data", bat_data, 0);
    check("rst_valid", bat_valid, 0);
    check("rst_last", bat_last, 0);
    check("rst_busy", bat_busy, 0);
    check("rst_done", bat_done, 0);
    @(posedge clk); #1;
    resetn = 0;

    // preload and a regfile read
    for (int i = 0; i < 8; i++) wr(8'(i), 8'(i + 'h10));
    rd(8'd5, 8'h15);

    // basic batch: 4 beats back to back
    bat_ready = 1;
    bat_q.push_back({1'b0, 8'h12}); bat_q.push_back({1'b0, 8'h13});
    bat_q.push_back({1'b0, 8'h14}); bat_q.push_back({1'b1, 8'h15});
    start(8'd2, 9'd4);
    wait_done(n, fv);
    check("first_valid_cycle", fv, 2);
    check("batch4_cycles", n, 6);

    // wrap past top of memory
    wr(8'd254, 8'hAA); wr(8'd255, 8'hBB); wr(8'd0, 8'hCC);
    bat_q.push_back({1'b0, 8'hAA}); bat_q.push_back({1'b0, 8'hBB});
    bat_q.push_back({1'b1, 8'hCC});
    start(8'd254, 9'd3);
    wait_done(n, fv);
    check("wrap_cycles", n, 5);

    // backpressure plus regfile contention; mem[0] now 0xCC
    bat_q.push_back({1'b0, 8'hCC});
    for (int i = 1; i < 8; i++) bat_q.push_back({i == 7, 8'(i + 'h10)});
    start(8'd0, 9'd8);
    for (int k = 0; k < 400; k++) begin
      bat_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        a = 8'($urandom_range(1, 7));
        RAM_CS = 1; RAM_RD = 1; RAM_Addr = a;
        ram_q.push_back(a + 8'h10);
      end else begin
        RAM_CS = 0; RAM_RD = 0;
      end
      @(negedge clk);
      if (bat_done) break;
      @(posedge clk); #1;
    end
    check("bp_done_seen", bat_done, 1);
    @(posedge clk); #1;
    RAM_CS = 0; RAM_RD = 0; bat_ready = 1;

    // empty batch
    empty_ok = 1;
    start(8'd0, 9'd0);
    @(negedge clk);
    check("empty_done", bat_done, 1);
    check("empty_busy", bat_busy, 1);
    check("empty_valid", bat_valid, 0);
    @(negedge clk);
    check("empty_done_clr", bat_done, 0);
    check("empty_idle", bat_busy, 0);
    check("empty_valid2", bat_valid, 0);
    @(posedge clk); #1;
    empty_ok = 0;

    // start while busy is ignored
    bat_q.push_back({1'b0, 8'h14}); bat_q.push_back({1'b0, 8'h15});
    bat_q.push_back({1'b1, 8'h16});
    start(8'd4, 9'd3);
    start(8'd0, 9'd5);
    wait_done(n, fv);
    @(negedge clk);
    check("ignored_start_idle", bat_busy, 0);
    check("ignored_start_valid", bat_valid, 0);
    @(posedge clk); #1;

    // reset mid-batch while a beat is presented
    bat_ready = 0;
    start(8'd1, 9'd5);
    for (int k = 0; k < 20 && !bat_valid; k++) @(negedge clk);
    check("pre_reset_valid", bat_valid, 1);
    @(posedge clk); #1;
    resetn = 1;
    @(posedge clk); #1;
    resetn = 0;
    bat_ready = 1;
    @(negedge clk);
    check("mid_rst_data", bat_data, 0);
    check("mid_rst_valid", bat_valid, 0);
    check("mid_rst_last", bat_last, 0);
    check("mid_rst_busy", bat_busy, 0);
    check("mid_rst_dataOut", RAM_dataOut, 0);
    check("mid_rst_rvalid", RAM_rvalid, 0);
    for (int k = 0; k < 3; k++) begin
      check("mid_rst_no_done", bat_done, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rd(8'd5, 8'h15);
    rd(8'd255, 8'hBB);
    rd(8'd0, 8'hCC);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ram_q_drained", ram_q.size(), 0);
    check("bat_q_drained", bat_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
